data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl.sv | 139 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory with byte/half/word loads and stores, clear-on-reset sweep,
// and a one-cycle registered response. Optional macro: DMEM_MISALIGN_TRAP_EN (trap misaligned half/word).
module data_memory_ctrl #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_2000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    output logic        READY,
    input  logic        WE,
    input  logic [31:0] A,
    input  logic [1:0]  SIZE,
    input  logic        UNS,
    input  logic [31:0] WD,
    output logic        RVALID,
    output logic [31:0] RD,
    output logic        ERR,
    output logic        STATE
);

    localparam int          DEPTH = 2 ** ADDR_W;
    localparam logic [32:0] LIMIT = 33'd4 << ADDR_W;

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [31:0]         mem [DEPTH];

    logic [31:0]         offset;
    logic [ADDR_W-1:0]   word_idx;
    logic                out_of_range;
    logic                misalign;
    logic                req_err;
    logic                accept;
    logic [3:0]          lane_mask;
    logic [31:0]         wdata;
    logic [31:0]         sel_word;
    logic [31:0]         shifted;
    logic [7:0]          byte_val;
    logic [15:0]         half_val;
    logic [31:0]         load_val;

    // Handshake: a request is taken on any rising edge where REQ and READY are both high;
    // its response (RVALID, RD, ERR) is presented for exactly the following cycle.
    always_comb begin
        offset       = A - BASE_ADDR;
        out_of_range = ({1'b0, offset} >= LIMIT);
        word_idx     = offset[ADDR_W+1:2];
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign     = (SIZE == 2'b01 && A[0]) || (SIZE == 2'b10 && A[1:0] != 2'b00);
`else
        misalign     = 1'b0;
`endif
        req_err      = out_of_range || (SIZE == 2'b11) || misalign;
        accept       = REQ && READY;

        sel_word     = mem[word_idx];
        shifted      = sel_word >> {A[1:0], 3'b000};
        byte_val     = shifted[7:0];
        half_val     = A[1] ? sel_word[31:16] : sel_word[15:0];

        lane_mask    = 4'b0000;
        wdata        = 32'h0;
        load_val     = 32'h0;
        // Low address bits below the access size are ignored, giving natural alignment.
        case (SIZE)
            2'b00: begin
                lane_mask = 4'b0001 << A[1:0];
                wdata     = {4{WD[7:0]}};
                load_val  = UNS ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
            end
            2'b01: begin
                lane_mask = A[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{WD[15:0]}};
                load_val  = UNS ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
            end
            2'b10: begin
                lane_mask = 4'b1111;
                wdata     = WD;
                load_val  = sel_word;
            end
            default: begin
                lane_mask = 4'b0000;
                wdata     = 32'h0;
                load_val  = 32'h0;
            end
        endcase
    end

    // Storage has no reset of its own; the INIT sweep zeroes it after every reset.
    always_ff @(posedge CLK) begin
        if (state == INIT) begin
            mem[clr_cnt] <= 32'h0;
        end else if (accept && WE && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= INIT;
            clr_cnt <= '0;
            READY   <= 1'b0;
            RVALID  <= 1'b0;
            ERR     <= 1'b0;
            RD      <= 32'h0;
        end else begin
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    RVALID  <= 1'b0;
                    ERR     <= 1'b0;
                    RD      <= 32'h0;
                    if (clr_cnt == '1) begin
                        state <= IDLE;
                        READY <= 1'b1;
                    end
                end
                IDLE: begin
                    READY  <= 1'b1;
                    RVALID <= accept;
                    ERR    <= accept && req_err;
                    RD     <= (accept && !WE && !req_err) ? load_val : 32'h0;
                end
                default: state <= INIT;
            endcase
        end
    end

    assign STATE = (state == IDLE);

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: byte-addressed reference model, directed and random accesses.
module tb_data_memory_ctrl;

    localparam int          ADDR_W = 10;
    localparam int          DEPTH  = 2 ** ADDR_W;
    localparam int          BYTES  = 4 * DEPTH;
    localparam logic [31:0] BASE   = 32'h0000_2000;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        REQ;
    logic        READY;
    logic        WE;
    logic [31:0] A;
    logic [1:0]  SIZE;
    logic        UNS;
    logic [31:0] WD;
    logic        RVALID;
    logic [31:0] RD;
    logic        ERR;
    logic        STATE;

    int vectors    = 0;
    int miscompares = 0;

    logic [7:0] mdl [BYTES];

    data_memory_ctrl #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .READY(READY), .WE(WE), .A(A),
        .SIZE(SIZE), .UNS(UNS), .WD(WD), .RVALID(RVALID), .RD(RD), .ERR(ERR),
        .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    // Reference: memory as a flat byte array, little-endian.
    task automatic model_access(input logic we, input logic [31:0] a, input logic [1:0] size,
                                input logic uns, input logic [31:0] wd,
                                output logic [31:0] e_rd, output logic e_err);
        logic [31:0] off;
        int          n;
        int          start;
        logic [31:0] v;
        off   = a - BASE;
        e_rd  = 32'h0;
        e_err = (size == 2'b11) || (off >= 32'(BYTES));
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00)) e_err = 1'b1;
`endif
        if (!e_err) begin
            n     = 1 << size;
            start = int'(off) & ~(n - 1);
            if (we) begin
                for (int i = 0; i < n; i++) mdl[start + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[start + i];
                if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                e_rd = v;
            end
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < BYTES; i++) mdl[i] = 8'h00;
    endtask

    // Called at a negedge; leaves REQ asserted so consecutive calls are back-to-back.
    task automatic issue(input logic we, input logic [31:0] a, input logic [1:0] size,
                         input logic uns, input logic [31:0] wd, input string name);
        logic [31:0] e_rd;
        logic        e_err;
        vectors++;
        if (READY !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready: got %b expected 1", name, READY);
        end
        REQ = 1'b1; WE = we; A = a; SIZE = size; UNS = uns; WD = wd;
        model_access(we, a, size, uns, wd, e_rd, e_err);
        @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (RVALID !== 1'b1) begin
            miscompares++;
            $display("FAIL %s rvalid: got %b expected 1", name, RVALID);
        end
        vectors++;
        if (ERR !== e_err) begin
            miscompares++;
            $display("FAIL %s err: got %b expected %b (a=%h size=%0d)", name, ERR, e_err, a, size);
        end
        vectors++;
        if (RD !== e_rd) begin
            miscompares++;
            $display("FAIL %s rd: got %h expected %h (a=%h size=%0d)", name, RD, e_rd, a, size);
        end
    endtask

    task automatic idle(input string name);
        REQ = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (RVALID !== 1'b0 || ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: got rvalid=%b err=%b expected 0 0", name, RVALID, ERR);
        end
    endtask

    task automatic check_const(input logic [31:0] act, input logic [31:0] exp, input string name);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Releases reset at a negedge with REQ held high and counts cycles READY stays low.
    task automatic release_and_count(input string name);
        int low;
        int seen_rvalid;
        low = 0;
        seen_rvalid = 0;
        REQ = 1'b1; WE = 1'b0; A = BASE; SIZE = 2'b10; UNS = 1'b0; WD = 32'h0;
        RST_N = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (READY === 1'b1) break;
            if (RVALID !== 1'b0) seen_rvalid++;
            low++;
            @(negedge CLK);
        end
        REQ = 1'b0;
        clear_model();
        check_const(32'(low), 32'd1024, {name, " ready_low_cycles"});
        check_const({31'h0, READY}, 32'h1, {name, " ready_after_init"});
        check_const({31'h0, STATE}, 32'h1, {name, " state_idle"});
        check_const(32'(seen_rvalid), 32'h0, {name, " no_rvalid_in_init"});
    endtask

    task automatic test_reset();
        RST_N = 1'b0; REQ = 1'b0; WE = 1'b0; A = '0; SIZE = '0; UNS = 1'b0; WD = '0;
        repeat (3) @(negedge CLK);
        check_const({31'h0, READY},  32'h0, "reset ready");
        check_const({31'h0, RVALID}, 32'h0, "reset rvalid");
        check_const({31'h0, ERR},    32'h0, "reset err");
        check_const(RD,              32'h0, "reset rd");
        check_const({31'h0, STATE},  32'h0, "reset state");
    endtask

    task automatic test_init();
        release_and_count("init");
        issue(1'b0, 32'h2000, 2'b10, 1'b0, 32'h0, "init_load0");
        idle("init_load0");
    endtask

    task automatic test_lanes();
        issue(1'b1, 32'h2004, 2'b10, 1'b0, 32'h8899AABB, "st_word");
        issue(1'b0, 32'h2007, 2'b00, 1'b0, 32'h0, "ld_byte_s");
        check_const(RD, 32'hFFFFFF88, "ld_byte_s const");
        issue(1'b0, 32'h2007, 2'b00, 1'b1, 32'h0, "ld_byte_u");
        check_const(RD, 32'h00000088, "ld_byte_u const");
        issue(1'b0, 32'h2004, 2'b01, 1'b0, 32'h0, "ld_half_s");
        check_const(RD, 32'hFFFFAABB, "ld_half_s const");
        issue(1'b1, 32'h2005, 2'b00, 1'b0, 32'hDEAD_BE11, "st_byte");
        issue(1'b0, 32'h2004, 2'b10, 1'b0, 32'h0, "ld_word_merge");
        check_const(RD, 32'h889911BB, "ld_word_merge const");
        idle("lanes");
        issue(1'b1, 32'h2012, 2'b01, 1'b0, 32'h1234_8001, "st_half_hi");
        issue(1'b0, 32'h2012, 2'b01, 1'b1, 32'h0, "ld_half_u");
        issue(1'b0, 32'h2010, 2'b10, 1'b0, 32'h0, "ld_word_hi");
        idle("half");
    endtask

    task automatic test_errors();
        issue(1'b1, 32'h1FFC, 2'b10, 1'b0, 32'hCAFE_F00D, "st_below");
        check_const({31'h0, ERR}, 32'h1, "st_below err const");
        issue(1'b1, 32'h3000, 2'b10, 1'b0, 32'hCAFE_F00D, "st_above");
        check_const({31'h0, ERR}, 32'h1, "st_above err const");
        issue(1'b0, 32'h3000, 2'b10, 1'b0, 32'h0, "ld_above");
        issue(1'b1, 32'h2008, 2'b11, 1'b0, 32'hFFFF_FFFF, "st_size3");
        issue(1'b0, 32'h2004, 2'b11, 1'b0, 32'h0, "ld_size3");
        issue(1'b0, 32'h2FFC, 2'b10, 1'b0, 32'h0, "ld_top");
        issue(1'b0, 32'h2002, 2'b10, 1'b0, 32'h0, "ld_misalign_word");
        issue(1'b0, 32'h2005, 2'b01, 1'b1, 32'h0, "ld_misalign_half");
        issue(1'b1, 32'h2003, 2'b10, 1'b0, 32'h5555_AAAA, "st_misalign_word");
        for (int i = 0; i < DEPTH; i++)
            issue(1'b0, BASE + 32'(4 * i), 2'b10, 1'b0, 32'h0, "reload");
        idle("errors");
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [1:0]  size;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = BASE + 32'(BYTES) - 32'($urandom_range(0, 7)) + 32'($urandom_range(0, 7));
                default: a = BASE + 32'($urandom_range(0, 63));
            endcase
            size = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            issue(1'($urandom_range(0, 1)), a, size, 1'($urandom_range(0, 1)), $urandom, "rand");
            if ($urandom_range(0, 7) == 0) idle("rand_gap");
        end
        idle("rand_end");
    endtask

    task automatic test_reset_abort();
        issue(1'b1, 32'h2020, 2'b10, 1'b0, 32'h0BAD_0BAD, "abort_a");
        issue(1'b0, 32'h2020, 2'b10, 1'b0, 32'h0, "abort_b");
        REQ = 1'b1; WE = 1'b0; A = 32'h2020; SIZE = 2'b10;
        @(posedge CLK);
        #1 RST_N = 1'b0;
        @(negedge CLK);
        check_const({31'h0, RVALID}, 32'h0, "abort rvalid");
        check_const({31'h0, ERR},    32'h0, "abort err");
        check_const(RD,              32'h0, "abort rd");
        check_const({31'h0, READY},  32'h0, "abort ready");
        REQ = 1'b0;
        @(negedge CLK);
        release_and_count("abort_stream");
        issue(1'b0, 32'h2020, 2'b10, 1'b0, 32'h0, "abort_cleared");
        idle("abort_cleared");

        issue(1'b1, 32'h2040, 2'b10, 1'b0, 32'h7777_7777, "midinit_seed");
        idle("midinit_seed");
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (500) @(posedge CLK);
        #1 RST_N = 1'b0;
        @(negedge CLK);
        check_const({31'h0, READY}, 32'h0, "midinit ready");
        check_const({31'h0, STATE}, 32'h0, "midinit state");
        @(negedge CLK);
        release_and_count("midinit");
        issue(1'b0, 32'h2040, 2'b10, 1'b0, 32'h0, "midinit_cleared");
        idle("midinit_cleared");
    endtask

    initial begin
        test_reset();
        test_init();
        test_lanes();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
